// File: rtl/des_pkg.sv
// Shared definitions for the DES key schedule: FSM encoding, per-round shift table,
// PC1 index table and C/D rotation helpers.
package des_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Left-shift count applied when producing round r from round r-1 (FIPS 46-3).
  localparam logic [1:0] SHIFT [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC1: output bit j (1-based) takes key bit PC1_TBL[j] (1-based, MSB first).
  localparam int unsigned PC1_TBL [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [1:0] shift_of(input logic [4:0] r);
    logic [1:0] n;
    n = 2'd2;
    for (int i = 1; i <= 16; i++) begin
      if (r == 5'(i)) n = SHIFT[i];
    end
    return n;
  endfunction

  // C occupies the upper 28 bits (FIPS bit 1 at the MSB), so a FIPS left shift
  // is an ordinary left rotate of each half.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] n,
                                         input logic left);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (left) begin
      c = (n == 2'd1) ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
      d = (n == 2'd1) ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
    end else begin
      c = (n == 2'd1) ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
      d = (n == 2'd1) ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
    end
    return {c, d};
  endfunction

endpackage

// File: rtl/des_key_sched_dec_if.sv
// Key-in / subkey-out stream bundle for the DES key schedule.
// The `enc` sideband exists only when DES_KS_ENC_EN is defined.
interface des_key_sched_dec_if;
`ifdef DES_KS_ENC_EN
  logic        enc;
`endif
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [4:0]  round;     // 5 bits so that round 16 is representable
  logic        last;

  modport slave (
`ifdef DES_KS_ENC_EN
    input  enc,
`endif
    input  key_valid, key, subkey_ready,
    output key_ready, subkey_valid, subkey, round, last
  );

  modport master (
`ifdef DES_KS_ENC_EN
    output enc,
`endif
    output key_valid, key, subkey_ready,
    input  key_ready, subkey_valid, subkey, round, last
  );
endinterface

// File: rtl/des_pc1.sv
// DES Permuted Choice 1: 64-bit key to 56-bit C||D, dropping the parity bits.
module des_pc1
  import des_pkg::*;
(
  input  logic [63:0] key,
  output logic [55:0] cd
);
  for (genvar j = 1; j <= 56; j++) begin : g_bit
    assign cd[56-j] = key[64-PC1_TBL[j]];
  end

  // Parity bits 8,16..64 sit at vector positions 56,48..0 and are not permuted.
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};
endmodule

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: 56-bit C||D to the 48-bit round subkey.
module des_pc2 (
  input  logic [55:0] cd,
  output logic [47:0] subkey
);
  localparam int unsigned PC2_TBL [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  for (genvar j = 1; j <= 48; j++) begin : g_bit
    assign subkey[48-j] = cd[56-PC2_TBL[j]];
  end

  // Positions 9,18,22,25,35,38,43,54 are discarded by PC2.
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};
endmodule

// File: rtl/des_key_sched_dec.sv
// Sequential DES key schedule emitting K16..K1 (decryption order) over valid/ready.
// Define DES_KS_ENC_EN to add an `enc` input selecting K1..K16 order instead.
module des_key_sched_dec
  import des_pkg::*;
(
  input logic               clk,
  input logic               rst,
  des_key_sched_dec_if.slave bus
);
  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [55:0] cd_load;
  logic [4:0]  round_q, round_d;
  logic [4:0]  last_round;
`ifdef DES_KS_ENC_EN
  logic        enc_q, enc_d;
`endif

  des_pc1 u_pc1 (.key(bus.key), .cd(cd_load));
  des_pc2 u_pc2 (.cd(cd_q), .subkey(bus.subkey));

`ifdef DES_KS_ENC_EN
  assign last_round = enc_q ? 5'd16 : 5'd1;
`else
  assign last_round = 5'd1;
`endif

  assign bus.key_ready    = (state_q == ST_IDLE);
  assign bus.subkey_valid = (state_q == ST_RUN);
  assign bus.round        = round_q;
  assign bus.last         = (state_q == ST_RUN) && (round_q == last_round);

  always_comb begin
    // NOTE: every variable gets a hold default first so no path can infer a latch.
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
`ifdef DES_KS_ENC_EN
    enc_d   = enc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          state_d = ST_RUN;
`ifdef DES_KS_ENC_EN
          enc_d = bus.enc;
          if (bus.enc) begin
            // K1 needs C1D1, so the first left shift happens at load.
            cd_d    = rot_cd(cd_load, 2'd1, 1'b1);
            round_d = 5'd1;
          end else begin
            cd_d    = cd_load;
            round_d = 5'd16;
          end
`else
          cd_d    = cd_load;
          round_d = 5'd16;
`endif
        end
      end
      ST_RUN: begin
        if (bus.subkey_ready) begin
          if (round_q == last_round) begin
            state_d = ST_IDLE;
            round_d = 5'd0;
          end else begin
`ifdef DES_KS_ENC_EN
            if (enc_q) begin
              cd_d    = rot_cd(cd_q, shift_of(round_q + 5'd1), 1'b1);
              round_d = round_q + 5'd1;
            end else begin
              cd_d    = rot_cd(cd_q, shift_of(round_q), 1'b0);
              round_d = round_q - 5'd1;
            end
`else
            // Undo the left shift that produced this round: C(r-1) = rotr(C(r)).
            cd_d    = rot_cd(cd_q, shift_of(round_q), 1'b0);
            round_d = round_q - 5'd1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      round_q <= '0;
`ifdef DES_KS_ENC_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
`ifdef DES_KS_ENC_EN
      enc_q   <= enc_d;
`endif
    end
  end
endmodule

// File: tb/tb_des_key_sched_dec.sv
// Directed bench for des_key_sched_dec: table of keys with known subkeys, plus
// backpressure, ignored key_valid, mid-run reset and (optionally) encrypt order.
module tb_des_key_sched_dec;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_sched_dec_if ifc ();
  des_key_sched_dec dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  // ks[n-1] holds Kn in FIPS numbering.
  typedef struct packed {
    logic [63:0]       key;
    logic [15:0][47:0] ks;
  } vec_t;

  vec_t        vecs [4];
  logic [47:0] kref [1:16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_key(input logic [63:0] k, input bit enc_mode);
    int c;
    c = 0;
    while (!ifc.key_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("key_ready_wait", {63'd0, ifc.key_ready}, 64'd1);
    ifc.key       = k;
    ifc.key_valid = 1'b1;
`ifdef DES_KS_ENC_EN
    ifc.enc = enc_mode;
`else
    if (enc_mode) check("enc_unsupported", 64'd1, 64'd0);
`endif
  endtask

  task automatic check_beats(input vec_t v, input bit enc_mode, input int n_beats,
                             input int stall_round, input bit hold_kv,
                             input logic [63:0] alt_key);
    for (int i = 0; i < n_beats; i++) begin
      int          r;
      logic [47:0] e;
      r = enc_mode ? i + 1 : 16 - i;
      e = v.ks[r-1];
      @(negedge clk);
      if (i == 0) begin
        ifc.key_valid = hold_kv;
        if (hold_kv) ifc.key = alt_key;
      end
      check("subkey_valid", {63'd0, ifc.subkey_valid}, 64'd1);
      check("round",        {59'd0, ifc.round}, 64'(r));
      check("subkey",       {16'd0, ifc.subkey}, {16'd0, e});
      check("last",         {63'd0, ifc.last}, (i == 15) ? 64'd1 : 64'd0);
      check("key_ready_run", {63'd0, ifc.key_ready}, 64'd0);
      if (r == stall_round) begin
        ifc.subkey_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_valid",  {63'd0, ifc.subkey_valid}, 64'd1);
          check("stall_round",  {59'd0, ifc.round}, 64'(r));
          check("stall_subkey", {16'd0, ifc.subkey}, {16'd0, e});
        end
        ifc.subkey_ready = 1'b1;
      end
    end
  endtask

  task automatic end_check();
    @(negedge clk);
    check("idle_key_ready", {63'd0, ifc.key_ready}, 64'd1);
    check("idle_valid",     {63'd0, ifc.subkey_valid}, 64'd0);
    check("idle_round",     {59'd0, ifc.round}, 64'd0);
    check("idle_last",      {63'd0, ifc.last}, 64'd0);
  endtask

  initial begin
    kref[1]  = 48'h1B02EFFC7072; kref[2]  = 48'h79AED9DBC9E5;
    kref[3]  = 48'h55FC8A42CF99; kref[4]  = 48'h72ADD6DB351D;
    kref[5]  = 48'h7CEC07EB53A8; kref[6]  = 48'h63A53E507B2F;
    kref[7]  = 48'hEC84B7F618BC; kref[8]  = 48'hF78A3AC13BFB;
    kref[9]  = 48'hE0DBEBEDE781; kref[10] = 48'hB1F347BA464F;
    kref[11] = 48'h215FD3DED386; kref[12] = 48'h7571F59467E9;
    kref[13] = 48'h97C5D1FABA41; kref[14] = 48'h5F43B7F2E73A;
    kref[15] = 48'hBF918D3D3F0A; kref[16] = 48'hCB3D8B0E17F5;

    vecs[0].key = 64'h133457799BBCDFF1;
    vecs[1].key = 64'h0000000000000000;
    vecs[2].key = 64'hFFFFFFFFFFFFFFFF;
    vecs[3].key = 64'hFEFEFEFEFEFEFEFE;
    for (int n = 1; n <= 16; n++) begin
      vecs[0].ks[n-1] = kref[n];
      vecs[1].ks[n-1] = 48'h000000000000;
      vecs[2].ks[n-1] = 48'hFFFFFFFFFFFF;
      vecs[3].ks[n-1] = 48'hFFFFFFFFFFFF;
    end

    rst              = 1'b1;
    ifc.key_valid    = 1'b0;
    ifc.key          = '0;
    ifc.subkey_ready = 1'b1;
`ifdef DES_KS_ENC_EN
    ifc.enc          = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_key_ready", {63'd0, ifc.key_ready}, 64'd1);
    check("rst_valid",     {63'd0, ifc.subkey_valid}, 64'd0);
    check("rst_subkey",    {16'd0, ifc.subkey}, 64'd0);
    check("rst_round",     {59'd0, ifc.round}, 64'd0);
    check("rst_last",      {63'd0, ifc.last}, 64'd0);
    rst = 1'b0;

    // Full schedules, no backpressure.
    for (int v = 0; v < 4; v++) begin
      send_key(vecs[v].key, 1'b0);
      check_beats(vecs[v], 1'b0, 16, 0, 1'b0, '0);
      end_check();
    end

    // Backpressure for three cycles at round 12.
    send_key(vecs[0].key, 1'b0);
    check_beats(vecs[0], 1'b0, 16, 12, 1'b0, '0);
    end_check();

    // key_valid held with another key during RUN; taken only after the IDLE cycle.
    send_key(vecs[0].key, 1'b0);
    check_beats(vecs[0], 1'b0, 16, 0, 1'b1, vecs[2].key);
    end_check();
    check_beats(vecs[2], 1'b0, 16, 0, 1'b0, '0);
    end_check();

    // Reset at round 9 discards the schedule; a fresh key then runs cleanly.
    send_key(vecs[0].key, 1'b0);
    check_beats(vecs[0], 1'b0, 8, 0, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid",     {63'd0, ifc.subkey_valid}, 64'd0);
    check("midrst_key_ready", {63'd0, ifc.key_ready}, 64'd1);
    check("midrst_round",     {59'd0, ifc.round}, 64'd0);
    check("midrst_subkey",    {16'd0, ifc.subkey}, 64'd0);
    rst = 1'b0;
    send_key(vecs[0].key, 1'b0);
    check_beats(vecs[0], 1'b0, 16, 0, 1'b0, '0);
    end_check();

`ifdef DES_KS_ENC_EN
    // Encryption order K1..K16 with last at round 16.
    send_key(vecs[0].key, 1'b1);
    check_beats(vecs[0], 1'b1, 16, 0, 1'b0, '0);
    end_check();
    ifc.enc = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
